// File: rtl/rpn_stack_master.sv
// RPN (postfix) ALU that keeps top-of-stack locally and drives push/pop on an external LIFO.
// Define RPN_MUL_EN to decode opcode 8 as MUL (NOS*TOS, low DWID bits); otherwise it is illegal.
module rpn_stack_master #(
    parameter int DWID = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            tok_valid,
    output logic            tok_ready,
    input  logic [3:0]      tok_op,
    input  logic [DWID-1:0] tok_data,
    output logic [DWID-1:0] tos,
    output logic            tos_v,
    output logic            err_underflow,
    output logic            err_overflow,
    output logic            err_illegal,
    input  logic            err_clr,
    output logic            stk_push,
    output logic            stk_pop,
    output logic [DWID-1:0] stk_din,
    input  logic [DWID-1:0] stk_dout,
    input  logic            stk_dout_v,
    input  logic            stk_empty,
    input  logic            stk_full
);

    typedef enum logic [1:0] {IDLE, POP, WAIT} state_t;

    localparam logic [3:0] OP_LIT  = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_DROP = 4'd6;
    localparam logic [3:0] OP_SWAP = 4'd7;
    localparam logic [3:0] OP_MUL  = 4'd8;

    state_t          state_q, state_d;
    logic [3:0]      op_q, op_d;
    logic [DWID-1:0] tos_q, tos_d;
    logic            tos_v_q, tos_v_d;
    logic            err_uf_q, err_uf_d;
    logic            err_ov_q, err_ov_d;
    logic            err_il_q, err_il_d;
    logic            is_binary;
    logic [DWID-1:0] alu_res;

    always_comb begin
        is_binary = (tok_op == OP_ADD) || (tok_op == OP_SUB) || (tok_op == OP_AND) ||
                    (tok_op == OP_OR)  || (tok_op == OP_XOR);
`ifdef RPN_MUL_EN
        if (tok_op == OP_MUL) is_binary = 1'b1;
`endif
    end

    // Operands: stk_dout is NOS, tos_q is TOS; op_q was latched when the token was taken.
    always_comb begin
        alu_res = '0;
        case (op_q)
            OP_ADD:  alu_res = stk_dout + tos_q;
            OP_SUB:  alu_res = stk_dout - tos_q;
            OP_AND:  alu_res = stk_dout & tos_q;
            OP_OR:   alu_res = stk_dout | tos_q;
            OP_XOR:  alu_res = stk_dout ^ tos_q;
`ifdef RPN_MUL_EN
            OP_MUL:  alu_res = stk_dout * tos_q;
`endif
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        tos_d     = tos_q;
        tos_v_d   = tos_v_q;
        err_uf_d  = err_clr ? 1'b0 : err_uf_q;
        err_ov_d  = err_clr ? 1'b0 : err_ov_q;
        err_il_d  = err_clr ? 1'b0 : err_il_q;
        tok_ready = 1'b0;
        stk_push  = 1'b0;
        stk_pop   = 1'b0;
        case (state_q)
            IDLE: begin
                tok_ready = 1'b1;
                if (tok_valid) begin
                    if (tok_op == OP_LIT) begin
                        if (!tos_v_q) begin
                            tos_d   = tok_data;
                            tos_v_d = 1'b1;
                        end else if (!stk_full) begin
                            stk_push = 1'b1;
                            tos_d    = tok_data;
                        end else begin
                            err_ov_d = 1'b1;
                        end
                    end else if (is_binary || tok_op == OP_SWAP) begin
                        if (tos_v_q && !stk_empty) begin
                            op_d    = tok_op;
                            state_d = POP;
                        end else begin
                            err_uf_d = 1'b1;
                        end
                    end else if (tok_op == OP_DROP) begin
                        if (!tos_v_q) begin
                            err_uf_d = 1'b1;
                        end else if (stk_empty) begin
                            tos_d   = '0;
                            tos_v_d = 1'b0;
                        end else begin
                            op_d    = tok_op;
                            state_d = POP;
                        end
                    end else begin
                        err_il_d = 1'b1;
                    end
                end
            end
            POP: begin
                stk_pop = 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                // The pop just freed a slot, so the SWAP write-back push can never hit a full stack.
                if (stk_dout_v) begin
                    state_d = IDLE;
                    if (op_q == OP_DROP) begin
                        tos_d = stk_dout;
                    end else if (op_q == OP_SWAP) begin
                        stk_push = 1'b1;
                        tos_d    = stk_dout;
                    end else begin
                        tos_d = alu_res;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= OP_LIT;
            tos_q    <= '0;
            tos_v_q  <= 1'b0;
            err_uf_q <= 1'b0;
            err_ov_q <= 1'b0;
            err_il_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            tos_q    <= tos_d;
            tos_v_q  <= tos_v_d;
            err_uf_q <= err_uf_d;
            err_ov_q <= err_ov_d;
            err_il_q <= err_il_d;
        end
    end

    assign tos           = tos_q;
    assign tos_v         = tos_v_q;
    assign stk_din       = tos_q;
    assign err_underflow = err_uf_q;
    assign err_overflow  = err_ov_q;
    assign err_illegal   = err_il_q;

endmodule
